// File: rtl/cnt100_bcd.sv
// Two-digit BCD modulo-100 up/down counter with synchronous saturating load and a
// combinational terminal-count flag for cascading into a following stage.
module cnt100_bcd (
  input  logic       CLK,
  input  logic       RESET_B,
  input  logic       LOAD,
  input  logic       EN,
  input  logic       UP,
  input  logic [7:0] IN,
  output logic [7:0] Q,
  output logic       CNT_99
);

  logic [3:0] units_q, units_d;
  logic [3:0] tens_q,  tens_d;
  logic       units_max, units_min;
  logic       tens_max,  tens_min;

  // Clamp a nibble to a legal decimal digit so Q never holds a non-BCD value.
  function automatic logic [3:0] sat_digit(input logic [3:0] d);
    sat_digit = (d > 4'd9) ? 4'd9 : d;
  endfunction

  assign units_max = (units_q == 4'd9);
  assign units_min = (units_q == 4'd0);
  assign tens_max  = (tens_q  == 4'd9);
  assign tens_min  = (tens_q  == 4'd0);

  always_comb begin
    units_d = units_q;
    tens_d  = tens_q;
    if (LOAD) begin
      // IN is only looked at here, so an undefined IN cannot reach the state.
      units_d = sat_digit(IN[3:0]);
      tens_d  = sat_digit(IN[7:4]);
    end else if (EN) begin
      if (UP) begin
        if (units_max) begin
          units_d = 4'd0;
          tens_d  = tens_max ? 4'd0 : tens_q + 4'd1;
        end else begin
          units_d = units_q + 4'd1;
        end
      end else begin
        if (units_min) begin
          units_d = 4'd9;
          tens_d  = tens_min ? 4'd9 : tens_q - 4'd1;
        end else begin
          units_d = units_q - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      units_q <= 4'd0;
      tens_q  <= 4'd0;
    end else begin
      units_q <= units_d;
      tens_q  <= tens_d;
    end
  end

  assign Q = {tens_q, units_q};

  // Gated by RESET_B so a held-down counter never signals a wrap to the next stage.
  assign CNT_99 = RESET_B & EN & ~LOAD &
                  ((UP & tens_max & units_max) | (~UP & tens_min & units_min));

endmodule

// File: tb/tb_cnt100_bcd.sv
// Self-checking bench for cnt100_bcd: directed vector table, reset corner sequence and
// randomized stimulus against a decimal-arithmetic reference model.
module tb_cnt100_bcd;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic       en;
  logic       up;
  logic [7:0] din;
  logic [7:0] q;
  logic       cnt_99;

  int n_checks;
  int n_fail;

  cnt100_bcd dut (
    .CLK    (clk),
    .RESET_B(rst_n),
    .LOAD   (load),
    .EN     (en),
    .UP     (up),
    .IN     (din),
    .Q      (q),
    .CNT_99 (cnt_99)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       load;
    logic       en;
    logic       up;
    logic [7:0] din;
    logic       exp_cnt;  // CNT_99 before the edge
    logic [7:0] exp_q;    // Q after the edge
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: value held as an integer 0..99.
  int model_v;

  function automatic int sat(input int d);
    return (d > 9) ? 9 : d;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t;
    logic [3:0] u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  function automatic logic model_cnt(input logic l, input logic e, input logic u, input int v);
    return e && !l && ((u && v == 99) || (!u && v == 0));
  endfunction

  function automatic int model_next(input logic l, input logic e, input logic u,
                                    input logic [7:0] d, input int v);
    if (l) return sat(int'(d[7:4])) * 10 + sat(int'(d[3:0]));
    if (!e) return v;
    return u ? (v + 1) % 100 : (v + 99) % 100;
  endfunction

  function automatic vec_t mk(input logic l, input logic e, input logic u, input logic [7:0] d,
                              input logic c, input logic [7:0] eq);
    vec_t r;
    r.load = l; r.en = e; r.up = u; r.din = d; r.exp_cnt = c; r.exp_q = eq;
    return r;
  endfunction

  // Drive on the falling edge, check CNT_99 before the rise and Q just after it.
  task automatic step(input string name, input logic l, input logic e, input logic u,
                      input logic [7:0] d, input logic c, input logic [7:0] eq);
    @(negedge clk);
    load = l; en = e; up = u; din = d;
    #1;
    check({name, ".cnt"}, {7'd0, cnt_99}, {7'd0, c});
    @(posedge clk);
    #1;
    check({name, ".q"}, q, eq);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1; din = 8'h00;
    #2;
    check("reset.q", q, 8'h00);
    check("reset.cnt", {7'd0, cnt_99}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // load/up, up wrap with a hold, down wrap, load priority, digit boundaries
    vecs.push_back(mk(1, 0, 1, 8'h95, 0, 8'h95));
    vecs.push_back(mk(0, 1, 1, 8'h00, 0, 8'h96));
    vecs.push_back(mk(0, 1, 1, 8'h00, 0, 8'h97));
    vecs.push_back(mk(0, 0, 1, 8'h00, 0, 8'h97));
    vecs.push_back(mk(0, 0, 1, 8'h00, 0, 8'h97));
    vecs.push_back(mk(0, 1, 1, 8'h00, 0, 8'h98));
    vecs.push_back(mk(0, 0, 1, 8'h00, 0, 8'h98));
    vecs.push_back(mk(0, 1, 1, 8'h00, 0, 8'h99));
    vecs.push_back(mk(0, 1, 1, 8'h00, 1, 8'h00));
    vecs.push_back(mk(0, 1, 1, 8'h00, 0, 8'h01));
    vecs.push_back(mk(1, 0, 0, 8'h04, 0, 8'h04));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 8'h03));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 8'h02));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 8'h01));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 8'h99));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 8'h98));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 8'h97));
    vecs.push_back(mk(1, 1, 1, 8'h3F, 0, 8'h39));
    vecs.push_back(mk(0, 0, 1, 8'hxx, 0, 8'h39));
    vecs.push_back(mk(1, 0, 1, 8'h09, 0, 8'h09));
    vecs.push_back(mk(0, 1, 1, 8'h00, 0, 8'h10));
    vecs.push_back(mk(1, 0, 1, 8'h19, 0, 8'h19));
    vecs.push_back(mk(0, 1, 1, 8'h00, 0, 8'h20));
    vecs.push_back(mk(1, 0, 0, 8'h10, 0, 8'h10));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 8'h09));
    vecs.push_back(mk(1, 0, 1, 8'hA3, 0, 8'h93));
    vecs.push_back(mk(1, 0, 1, 8'hFF, 0, 8'h99));
    vecs.push_back(mk(1, 1, 1, 8'h00, 0, 8'h00));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 8'h99));
    vecs.push_back(mk(0, 0, 1, 8'h00, 0, 8'h99));

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i].load, vecs[i].en, vecs[i].up, vecs[i].din,
           vecs[i].exp_cnt, vecs[i].exp_q);
    end

    // Asynchronous reset mid-count from 47 while a down-wrap condition would otherwise hold.
    step("pre_rst", 1, 0, 1, 8'h47, 0, 8'h47);
    @(negedge clk);
    load = 1'b0; en = 1'b1; up = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.q", q, 8'h00);
    check("async_rst.cnt", {7'd0, cnt_99}, 8'h00);
    @(posedge clk);
    #1;
    check("rst_held.q", q, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    up = 1'b1;
    @(posedge clk);
    #1;
    check("rst_release.q", q, 8'h01);

    // Randomized run against the reference model.
    model_v = 1;
    for (int i = 0; i < 400; i++) begin
      logic       l;
      logic       e;
      logic       u;
      logic [7:0] d;
      logic       c;
      l = ($urandom_range(0, 7) == 0);
      e = ($urandom_range(0, 3) != 0);
      u = 1'($urandom);
      d = 8'($urandom);
      // Bias loads toward the wrap points so CNT_99 is exercised often.
      if (l && $urandom_range(0, 1) == 1) d = u ? 8'h98 : 8'h01;
      c = model_cnt(l, e, u, model_v);
      model_v = model_next(l, e, u, d, model_v);
      step($sformatf("rnd%0d", i), l, e, u, d, c, to_bcd(model_v));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
